icache_responder: RTL and testbench

- Instruction-fetch responder that sits at the far end of the PC's ce/pc request interface.
- Each cycle the PC drives ce=1 with a byte address; this block returns the 32-bit instruction word from a small direct-mapped instruction cache.
- On a miss it raises a stall to the staller, refills the line word-by-word from the memory port, then delivers the instruction.
- A ROB redirect (flush) discards any in-flight response.

---
 rtl/icache_responder.sv | 172 +++++++++++++++++
 tb/tb_icache_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache that answers PC fetches, stalling and refilling
// a whole line word-by-word from the memory port on a miss.
module icache_responder #(
    parameter int unsigned Inst_Addr_Width = 32,
    parameter int unsigned Inst_Width      = 32,
    parameter int unsigned Line_Num        = 16,
    parameter int unsigned Words_Per_Line  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [Inst_Addr_Width-1:0] pc,
    input  logic                       flush,
    output logic [Inst_Width-1:0]      inst,
    output logic                       inst_valid,
    output logic [Inst_Addr_Width-1:0] inst_pc,
    output logic                       icache_stall,
    output logic                       mem_req,
    output logic [Inst_Addr_Width-1:0] mem_addr,
    input  logic                       mem_ready,
    input  logic [Inst_Width-1:0]      mem_data
);

    localparam int unsigned OFF_W = $clog2(Words_Per_Line);
    localparam int unsigned IDX_W = $clog2(Line_Num);
    localparam int unsigned TAG_W = Inst_Addr_Width - IDX_W - OFF_W - 2;
    localparam int unsigned IDX_LO = OFF_W + 2;
    localparam int unsigned TAG_LO = IDX_W + OFF_W + 2;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t state, state_nxt;

    logic [Inst_Width-1:0] data_mem [Line_Num*Words_Per_Line];
    logic [TAG_W-1:0]      tag_mem  [Line_Num];
    logic [Line_Num-1:0]   valid_q;

    logic [OFF_W-1:0]           cnt, cnt_nxt;
    logic [Inst_Addr_Width-1:0] miss_pc, miss_pc_nxt;
    logic                       flush_flag, flush_flag_nxt;

    logic [Inst_Width-1:0]      inst_nxt;
    logic [Inst_Addr_Width-1:0] inst_pc_nxt;
    logic                       inst_valid_nxt;
    logic                       stall_nxt;
    logic                       mem_req_nxt;
    logic [Inst_Addr_Width-1:0] mem_addr_nxt;
    logic                       fill_we;
    logic                       line_done;

    logic [OFF_W-1:0] req_off, miss_off;
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic             req_hit;
    logic             unused_pc_bits;

    assign req_off  = pc[IDX_LO-1:2];
    assign req_idx  = pc[TAG_LO-1:IDX_LO];
    assign req_tag  = pc[Inst_Addr_Width-1:TAG_LO];
    assign miss_off = miss_pc[IDX_LO-1:2];
    assign miss_idx = miss_pc[TAG_LO-1:IDX_LO];
    assign miss_tag = miss_pc[Inst_Addr_Width-1:TAG_LO];
    assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign unused_pc_bits = ^pc[1:0];

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        miss_pc_nxt    = miss_pc;
        flush_flag_nxt = flush_flag;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = 1'b0;
        stall_nxt      = icache_stall;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        fill_we        = 1'b0;
        line_done      = 1'b0;

        case (state)
            IDLE: begin
                if (ce) begin
                    if (req_hit) begin
                        inst_nxt       = data_mem[{req_idx, req_off}];
                        inst_pc_nxt    = pc;
                        inst_valid_nxt = ~flush;
                    end else begin
                        // A redirect on the missing cycle makes the eventual response wrong-path
                        stall_nxt      = 1'b1;
                        miss_pc_nxt    = pc;
                        cnt_nxt        = '0;
                        flush_flag_nxt = flush;
                        mem_req_nxt    = 1'b1;
                        mem_addr_nxt   = {req_tag, req_idx, OFF_W'(0), 2'b00};
                        state_nxt      = FILL;
                    end
                end
            end
            FILL: begin
                if (flush) begin
                    flush_flag_nxt = 1'b1;
                end
                if (mem_req && mem_ready) begin
                    fill_we = 1'b1;
                    cnt_nxt = cnt + OFF_W'(1);
                    if (cnt == OFF_W'(Words_Per_Line - 1)) begin
                        line_done   = 1'b1;
                        mem_req_nxt = 1'b0;
                        state_nxt   = RESP;
                    end else begin
                        mem_addr_nxt = {miss_tag, miss_idx, cnt + OFF_W'(1), 2'b00};
                    end
                end
            end
            RESP: begin
                inst_nxt       = data_mem[{miss_idx, miss_off}];
                inst_pc_nxt    = miss_pc;
                inst_valid_nxt = ~flush & ~flush_flag;
                stall_nxt      = 1'b0;
                flush_flag_nxt = 1'b0;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            miss_pc      <= '0;
            flush_flag   <= 1'b0;
            valid_q      <= '0;
            inst         <= '0;
            inst_pc      <= '0;
            inst_valid   <= 1'b0;
            icache_stall <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            miss_pc      <= miss_pc_nxt;
            flush_flag   <= flush_flag_nxt;
            inst         <= inst_nxt;
            inst_pc      <= inst_pc_nxt;
            inst_valid   <= inst_valid_nxt;
            icache_stall <= stall_nxt;
            mem_req      <= mem_req_nxt;
            mem_addr     <= mem_addr_nxt;
            if (line_done) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Line storage; contents are meaningless until the line's valid bit is set
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            data_mem[{miss_idx, cnt}] <= mem_data;
        end
        if (!rst && line_done) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hits, eviction, mid-line miss,
// flush during fill and in idle, and reset in the middle of a fill.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    icache_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .pc           (pc),
        .flush        (flush),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .icache_stall (icache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns the four words of a line, one mem_ready pulse each; flush rides word flush_at
    task automatic fill_line(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input int flush_at);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            chk("fill_addr", mem_addr, base + 32'(4 * i));
            chk("fill_req", 32'(mem_req), 32'd1);
            chk("fill_stall", 32'(icache_stall), 32'd1);
            mem_ready = 1'b1;
            mem_data  = d[i];
            flush     = (i == flush_at);
            step();
            mem_ready = 1'b0;
            flush     = 1'b0;
        end
        chk("resp_req_low", 32'(mem_req), 32'd0);
        chk("resp_stall_held", 32'(icache_stall), 32'd1);
        chk("resp_no_valid_yet", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pc = '0; flush = 1'b0; mem_ready = 1'b0; mem_data = '0;
        step();
        step();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_stall", 32'(icache_stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;

        // Cold miss at 0x00
        ce = 1'b1; pc = 32'h00;
        step();
        chk("cold_stall", 32'(icache_stall), 32'd1);
        chk("cold_valid", 32'(inst_valid), 32'd0);
        fill_line(32'h00, 32'h11, 32'h22, 32'h33, 32'h44, 4);
        step();
        chk("cold_inst", inst, 32'h11);
        chk("cold_inst_pc", inst_pc, 32'h00);
        chk("cold_valid_resp", 32'(inst_valid), 32'd1);
        chk("cold_stall_drop", 32'(icache_stall), 32'd0);

        // Hit stream
        pc = 32'h04; step();
        chk("hit4_inst", inst, 32'h22);
        chk("hit4_valid", 32'(inst_valid), 32'd1);
        chk("hit4_pc", inst_pc, 32'h04);
        pc = 32'h08; step();
        chk("hit8_inst", inst, 32'h33);
        chk("hit8_req", 32'(mem_req), 32'd0);
        pc = 32'h0C; step();
        chk("hitc_inst", inst, 32'h44);
        chk("hitc_stall", 32'(icache_stall), 32'd0);
        ce = 1'b0; step();
        chk("ce_low_valid", 32'(inst_valid), 32'd0);

        // Conflict eviction: 0x100 shares index 0
        ce = 1'b1; pc = 32'h100; step();
        chk("evict_stall", 32'(icache_stall), 32'd1);
        fill_line(32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
        step();
        chk("evict_inst", inst, 32'hA0);
        chk("evict_pc", inst_pc, 32'h100);
        pc = 32'h00; step();
        chk("evicted_miss", 32'(icache_stall), 32'd1);
        chk("evicted_valid", 32'(inst_valid), 32'd0);
        fill_line(32'h00, 32'h11, 32'h22, 32'h33, 32'h44, 4);
        step();
        chk("refill_inst", inst, 32'h11);

        // Mid-line miss fetches from offset 0 upward
        pc = 32'h18; step();
        chk("mid_stall", 32'(icache_stall), 32'd1);
        fill_line(32'h10, 32'h55, 32'h66, 32'h77, 32'h88, 4);
        step();
        chk("mid_inst", inst, 32'h77);
        chk("mid_pc", inst_pc, 32'h18);
        chk("mid_valid", 32'(inst_valid), 32'd1);

        // Flush during fill, coinciding with the third word
        pc = 32'h24; step();
        fill_line(32'h20, 32'h91, 32'h92, 32'h93, 32'h94, 2);
        step();
        chk("flush_resp_valid", 32'(inst_valid), 32'd0);
        chk("flush_resp_stall", 32'(icache_stall), 32'd0);
        pc = 32'h28; step();
        chk("flush_line_hit", inst, 32'h93);
        chk("flush_line_valid", 32'(inst_valid), 32'd1);

        // Flush in idle suppresses a hit
        pc = 32'h20; flush = 1'b1; step();
        flush = 1'b0;
        chk("idle_flush_valid", 32'(inst_valid), 32'd0);
        chk("idle_flush_stall", 32'(icache_stall), 32'd0);

        // Reset after the second word of a fill
        pc = 32'h34; step();
        chk("rmf_stall", 32'(icache_stall), 32'd1);
        chk("rmf_addr0", mem_addr, 32'h30);
        mem_ready = 1'b1; mem_data = 32'hC1; step();
        chk("rmf_addr1", mem_addr, 32'h34);
        mem_data = 32'hC2; step();
        mem_ready = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0;
        chk("rmf_req", 32'(mem_req), 32'd0);
        chk("rmf_stall_low", 32'(icache_stall), 32'd0);
        chk("rmf_addr_rst", mem_addr, 32'h0);
        step();
        chk("rmf_remiss", 32'(icache_stall), 32'd1);
        fill_line(32'h30, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 4);
        step();
        chk("rmf_inst", inst, 32'hD2);
        chk("rmf_inst_pc", inst_pc, 32'h34);

        // Earlier lines were wiped by the reset as well
        pc = 32'h04; step();
        chk("post_rst_miss", 32'(icache_stall), 32'd1);
        fill_line(32'h00, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 4);
        step();
        chk("post_rst_inst", inst, 32'hE1);
        ce = 1'b0; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
